// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared widths and 800x600@60 raster timing constants for the
//                video chain.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Counter and colour widths
  localparam int CNT_W = 11;
  localparam int RGB_W = 12;

  // Largest line/frame total an 11-bit counter can represent
  localparam int CNT_LIMIT = 1 << CNT_W;

  // 800x600@60 horizontal timing (pixels)
  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;

  // 800x600@60 vertical timing (lines)
  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;

  // Totals for the default mode
  localparam int HCOUNT_MAX = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VCOUNT_MAX = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : Raster bundle passed between the timing generator, the draw
//                stages and the frame buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_if;

  logic [vga_pkg::CNT_W-1:0] hcount;
  logic [vga_pkg::CNT_W-1:0] vcount;
  logic                      hsync;
  logic                      vsync;
  logic                      hblnk;
  logic                      vblnk;
  logic [vga_pkg::RGB_W-1:0] rgb;

  // Producer side
  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  // Consumer side
  modport sink (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

endinterface : vga_if
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_counter
//  Description : One raster axis: wrapping position counter with registered
//                blank and sync decode. Count, blank and sync are all loaded
//                from the same next-count value so they never skew.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   TOTAL      = HCOUNT_MAX,
  parameter int   ACTIVE     = VGA_H_ACTIVE,
  parameter int   SYNC_START = VGA_H_ACTIVE + VGA_H_FP,
  parameter int   SYNC_LEN   = VGA_H_SYNC,
  parameter logic POL        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             blank_o,
  output logic             sync_o,
  output logic             wrap_o
);

  // Decode thresholds, one bit wider than the counter so a sync window that
  // ends exactly at the counter range still compares correctly.
  localparam logic [CNT_W:0]   LAST_C     = (CNT_W+1)'(TOTAL - 1);
  localparam logic [CNT_W:0]   ACTIVE_C   = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0]   SS_C       = (CNT_W+1)'(SYNC_START);
  localparam logic [CNT_W:0]   SE_C       = (CNT_W+1)'(SYNC_START + SYNC_LEN);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             blank_q, blank_d;
  logic             sync_q,  sync_d;
  logic [CNT_W:0]   w_count_ext_q;
  logic [CNT_W:0]   w_count_ext_d;
  logic             w_wrap;

  assign w_count_ext_q = {1'b0, count_q};
  assign w_wrap        = inc_i && (w_count_ext_q == LAST_C);

  // Next position and the decode of that same position
  always_comb begin
    count_d = count_q;
    if (w_wrap) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + ONE_C;
    end
    w_count_ext_d = {1'b0, count_d};
    blank_d       = (w_count_ext_d >= ACTIVE_C);
    sync_d        = ((w_count_ext_d >= SS_C) && (w_count_ext_d < SE_C)) ? POL : ~POL;
  end

  // Position, blank and sync registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      blank_q <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign blank_o = blank_q;
  assign sync_o  = sync_q;
  assign wrap_o  = w_wrap;

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Free-running VGA raster timing generator. Horizontal axis
//                advances on the pixel strobe; its wrap advances the vertical
//                axis. Drives a constant background colour for later stages.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int               H_ACTIVE  = VGA_H_ACTIVE,
  parameter int               H_FP      = VGA_H_FP,
  parameter int               H_SYNC    = VGA_H_SYNC,
  parameter int               H_BP      = VGA_H_BP,
  parameter int               V_ACTIVE  = VGA_V_ACTIVE,
  parameter int               V_FP      = VGA_V_FP,
  parameter int               V_SYNC    = VGA_V_SYNC,
  parameter int               V_BP      = VGA_V_BP,
  parameter logic             HSYNC_POL = 1'b1,
  parameter logic             VSYNC_POL = 1'b1,
  parameter logic [RGB_W-1:0] BG_RGB    = 12'h000
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  vga_if.out   out,
  output logic frame_start,
  output logic line_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Refuse to build a mode the 11-bit counters cannot represent
  if (H_TOTAL > CNT_LIMIT) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > CNT_LIMIT) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds counter range");
  end

  logic [CNT_W-1:0] w_hcount;
  logic [CNT_W-1:0] w_vcount;
  logic             w_hsync, w_vsync, w_hblnk, w_vblnk;
  logic             w_h_wrap, w_v_wrap;
  logic             frame_start_q, frame_start_d;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .POL        (HSYNC_POL)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (pix_en),
    .count_o (w_hcount),
    .blank_o (w_hblnk),
    .sync_o  (w_hsync),
    .wrap_o  (w_h_wrap)
  );

  // Vertical axis steps once per completed line
  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .POL        (VSYNC_POL)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (w_h_wrap),
    .count_o (w_vcount),
    .blank_o (w_vblnk),
    .sync_o  (w_vsync),
    .wrap_o  (w_v_wrap)
  );

  // The vertical wrap can only occur together with a horizontal wrap, so it
  // marks the edge on which both counts return to (0,0).
  assign frame_start_d = w_v_wrap;

  // Frame-start pulse register, aligned with the counts it describes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign out.hcount  = w_hcount;
  assign out.vcount  = w_vcount;
  assign out.hsync   = w_hsync;
  assign out.vsync   = w_vsync;
  assign out.hblnk   = w_hblnk;
  assign out.vblnk   = w_vblnk;
  assign out.rgb     = BG_RGB;
  assign frame_start = frame_start_q;
  assign line_end    = w_h_wrap;

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Scoreboard bench for vga_timing_gen. A small-mode instance
//                (inverted polarities, non-zero background) and a default
//                800x600 instance are driven with the same random strobe and
//                reset stimulus and compared every cycle against a frame-
//                position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  // Small mode: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6)
  localparam int          S_HA = 4, S_HF = 1, S_HS = 2, S_HB = 1;
  localparam int          S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1;
  localparam bit          S_HP = 1'b0, S_VP = 1'b0;
  localparam logic [11:0] S_BG = 12'hF0F;
  localparam int          S_N  = (S_HA+S_HF+S_HS+S_HB) * (S_VA+S_VF+S_VS+S_VB);

  // Default mode: 800x600@60
  localparam int          B_HA = 800, B_HF = 40, B_HS = 128, B_HB = 88;
  localparam int          B_VA = 600, B_VF = 1,  B_VS = 4,   B_VB = 23;
  localparam bit          B_HP = 1'b1, B_VP = 1'b1;
  localparam logic [11:0] B_BG = 12'h000;
  localparam int          B_N  = (B_HA+B_HF+B_HS+B_HB) * (B_VA+B_VF+B_VS+B_VB);

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb, fs, le;
    logic [11:0] rgb;
  } exp_t;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic pix_en = 1'b0;

  logic fs_s, le_s, fs_b, le_b;

  vga_if vif_s ();
  vga_if vif_b ();

  exp_t q_s[$];
  exp_t q_b[$];

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  done     = 1'b0;

  // Reference state: linear position within the frame plus the pulse flag
  int  p_s = 0, p_b = 0;
  bit  f_s = 1'b0, f_b = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HSYNC_POL(S_HP), .VSYNC_POL(S_VP), .BG_RGB(S_BG)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_en(pix_en), .out(vif_s),
    .frame_start(fs_s), .line_end(le_s)
  );

  vga_timing_gen dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .out(vif_b),
    .frame_start(fs_b), .line_end(le_b)
  );

  // Expected outputs for a given frame position
  function automatic exp_t model(input int p, input bit fs, input bit pe,
                                 input int ha, input int hf, input int hsy, input int hbp,
                                 input int va, input int vf, input int vsy,
                                 input bit hp, input bit vp, input logic [11:0] bg);
    exp_t e;
    int   ht = ha + hf + hsy + hbp;
    int   h  = p % ht;
    int   v  = p / ht;
    e.h   = 11'(h);
    e.v   = 11'(v);
    e.hb  = (h >= ha);
    e.vb  = (v >= va);
    e.hs  = ((h >= ha + hf) && (h < ha + hf + hsy)) ? hp : !hp;
    e.vs  = ((v >= va + vf) && (v < va + vf + vsy)) ? vp : !vp;
    e.fs  = fs;
    e.le  = pe && (h == ht - 1);
    e.rgb = bg;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic reset_model();
    p_s = 0; p_b = 0; f_s = 1'b0; f_b = 1'b0;
  endtask

  // One clock of stimulus: account for the edge, then apply new inputs 2 ns
  // later (a rising rst here is asynchronous, between edges) and push the
  // response the DUT must show for the rest of the cycle.
  task automatic step(input bit r_new, input bit pe_new);
    @(posedge clk);
    if (rst) begin
      reset_model();
    end else if (pix_en) begin
      f_s = (p_s == S_N - 1); p_s = (p_s + 1) % S_N;
      f_b = (p_b == B_N - 1); p_b = (p_b + 1) % B_N;
    end else begin
      f_s = 1'b0; f_b = 1'b0;
    end
    #2;
    rst    = r_new;
    pix_en = pe_new;
    if (r_new) reset_model();
    q_s.push_back(model(p_s, f_s, pe_new, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_HP, S_VP, S_BG));
    q_b.push_back(model(p_b, f_b, pe_new, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_HP, B_VP, B_BG));
  endtask

  // Monitor: sample mid-cycle and compare against the oldest expectation
  initial begin
    exp_t es, eb;
    forever begin
      @(negedge clk);
      if (done) break;
      if (q_s.size() != 0 && q_b.size() != 0) begin
        es = q_s.pop_front();
        eb = q_b.pop_front();
        check("s.hcount",      32'(vif_s.hcount), 32'(es.h));
        check("s.vcount",      32'(vif_s.vcount), 32'(es.v));
        check("s.hsync",       32'(vif_s.hsync),  32'(es.hs));
        check("s.vsync",       32'(vif_s.vsync),  32'(es.vs));
        check("s.hblnk",       32'(vif_s.hblnk),  32'(es.hb));
        check("s.vblnk",       32'(vif_s.vblnk),  32'(es.vb));
        check("s.rgb",         32'(vif_s.rgb),    32'(es.rgb));
        check("s.frame_start", 32'(fs_s),         32'(es.fs));
        check("s.line_end",    32'(le_s),         32'(es.le));
        check("b.hcount",      32'(vif_b.hcount), 32'(eb.h));
        check("b.vcount",      32'(vif_b.vcount), 32'(eb.v));
        check("b.hsync",       32'(vif_b.hsync),  32'(eb.hs));
        check("b.vsync",       32'(vif_b.vsync),  32'(eb.vs));
        check("b.hblnk",       32'(vif_b.hblnk),  32'(eb.hb));
        check("b.vblnk",       32'(vif_b.vblnk),  32'(eb.vb));
        check("b.rgb",         32'(vif_b.rgb),    32'(eb.rgb));
        check("b.frame_start", 32'(fs_b),         32'(eb.fs));
        check("b.line_end",    32'(le_b),         32'(eb.le));
      end
    end
  end

  // Stimulus
  initial begin
    // Held in reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    // Full-rate run: one full default line plus many small frames
    for (int i = 0; i < 1100; i++) step(1'b0, 1'b1);
    // Half-rate strobe
    for (int i = 0; i < 300; i++) step(1'b0, (i % 2) == 0);
    // Random strobe with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 97) == 0, ($urandom % 4) != 0);
    end
    // Mid-line reset followed by recovery over another full default line
    for (int i = 0; i < 500; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 1100; i++) step(1'b0, 1'b1);
    // Let the final expectation be consumed
    @(negedge clk);
    #1;
    done = 1'b1;
    check("scoreboard_s_drained", 32'(q_s.size()), 32'd0);
    check("scoreboard_b_drained", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_vga_timing_gen
`default_nettype wire
